// File: rtl/add_csv_pkg.sv
// Shared sizing helpers for the carry-save resolve pipeline.
// Used by the CSA stage, the resolve adder and its testbench.
package add_csv_pkg;

  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Every stage resolves `chunk` bits except the last, which takes what is left.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned chunk,
                                              input int unsigned k);
    return (k == num_stages(width, chunk) - 1) ? width - k * chunk : chunk;
  endfunction

endpackage

// File: rtl/add_csv_resolve_stage.sv
// One pipeline stage of the carry-save resolver: adds bits [LO +: CW] of S/C
// plus the incoming carry and registers the result with a valid/ready handshake.
module add_csv_resolve_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LO    = 0,
  parameter int unsigned CW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Bits at or below this stage's chunk are resolved; only the upper S/C bits travel on.
  localparam logic [WIDTH-1:0] RES_MASK = {WIDTH{1'b1}} >> (WIDTH - LO - CW);

  logic             valid_q;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q;
  logic [CW:0]      add;
  logic             advance;

  always_comb begin
    add = {1'b0, s_i[LO +: CW]} + {1'b0, c_i[LO +: CW]} + {{CW{1'b0}}, carry_i};
  end

  always_comb begin
    sum_d            = sum_i;
    sum_d[LO +: CW]  = add[CW-1:0];
    s_d              = s_i & ~RES_MASK;
    c_d              = c_i & ~RES_MASK;
  end

  assign advance = !valid_q || ready_i;
  assign ready_o = advance;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_i;
      if (valid_i) begin
        s_q     <= s_d;
        c_q     <= c_d;
        sum_q   <= sum_d;
        carry_q <= add[CW];
      end
    end
  end

  assign valid_o = valid_q;
  assign s_o     = s_q;
  assign c_o     = c_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/add_csv_resolve.sv
// Pipelined carry-propagate adder resolving a carry-save pair (S, C) into a
// binary sum, CHUNK bits per stage, with full-throughput valid/ready handshakes.
module add_csv_resolve
  import add_csv_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] S_i,
  input  logic [WIDTH-1:0] C_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);

  localparam int unsigned NSTAGES = num_stages(WIDTH, CHUNK);

  // Index k is the input side of stage k; index NSTAGES is the block output.
  logic [WIDTH-1:0] s_p     [NSTAGES+1];
  logic [WIDTH-1:0] c_p     [NSTAGES+1];
  logic [WIDTH-1:0] sum_p   [NSTAGES+1];
  logic             carry_p [NSTAGES+1];
  logic             valid_p [NSTAGES+1];
  logic             ready_p [NSTAGES+1];

  assign s_p[0]           = S_i;
  assign c_p[0]           = C_i;
  assign sum_p[0]         = '0;
  assign carry_p[0]       = 1'b0;
  assign valid_p[0]       = valid_i;
  assign ready_p[NSTAGES] = ready_i;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int unsigned CW = chunk_width(WIDTH, CHUNK, k);

    add_csv_resolve_stage #(
      .WIDTH (WIDTH),
      .LO    (k * CHUNK),
      .CW    (CW)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .valid_i (valid_p[k]),
      .ready_o (ready_p[k]),
      .s_i     (s_p[k]),
      .c_i     (c_p[k]),
      .sum_i   (sum_p[k]),
      .carry_i (carry_p[k]),
      .valid_o (valid_p[k+1]),
      .ready_i (ready_p[k+1]),
      .s_o     (s_p[k+1]),
      .c_o     (c_p[k+1]),
      .sum_o   (sum_p[k+1]),
      .carry_o (carry_p[k+1])
    );
  end

  // A clear wins over a same-cycle offer, so the input is refused outright.
  assign ready_o = ready_p[0] && !clr_i;
  assign valid_o = valid_p[NSTAGES];
  assign sum_o   = sum_p[NSTAGES];
  assign co_o    = carry_p[NSTAGES];

endmodule

// File: tb/tb_add_csv_resolve.sv
// Bench for add_csv_resolve: directed scenarios on an 8/4 instance plus random
// carry-save streams into 13/4 and 13/16 instances, all checked against a queue model.
module tb_add_csv_resolve;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  // Directed instance, WIDTH=8 CHUNK=4
  logic       v0, r0, clr0, rdyo0, vo0, co0;
  logic [7:0] s0, c0, sum0;

  // Random instances: [0] WIDTH=13 CHUNK=4, [1] WIDTH=13 CHUNK=16
  logic        vin_r  [2];
  logic        rdy_r  [2];
  logic        rdyo_r [2];
  logic        vout_r [2];
  logic        co_r   [2];
  logic [12:0] s_r    [2];
  logic [12:0] c_r    [2];
  logic [12:0] sum_r  [2];
  logic        rand_done;

  // Model: per-DUT queue of expected {co, sum} and the edge each entry was accepted on.
  logic [16:0] eq [3][$];
  int          aq [3][$];

  add_csv_resolve #(.WIDTH(8), .CHUNK(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr0), .valid_i(v0), .ready_o(rdyo0),
    .S_i(s0), .C_i(c0), .valid_o(vo0), .ready_i(r0), .sum_o(sum0), .co_o(co0));

  add_csv_resolve #(.WIDTH(13), .CHUNK(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0), .valid_i(vin_r[0]), .ready_o(rdyo_r[0]),
    .S_i(s_r[0]), .C_i(c_r[0]), .valid_o(vout_r[0]), .ready_i(rdy_r[0]),
    .sum_o(sum_r[0]), .co_o(co_r[0]));

  add_csv_resolve #(.WIDTH(13), .CHUNK(16)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0), .valid_i(vin_r[1]), .ready_o(rdyo_r[1]),
    .S_i(s_r[1]), .C_i(c_r[1]), .valid_o(vout_r[1]), .ready_i(rdy_r[1]),
    .sum_o(sum_r[1]), .co_o(co_r[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Evaluated once per cycle at the falling edge, when inputs and ready_o are settled.
  task automatic mon(input int id, input int w, input int ns, input logic rst, input logic clr,
                     input logic vin, input logic rdyo, input logic [15:0] s, input logic [15:0] c,
                     input logic vout, input logic rdyi, input logic [15:0] sum, input logic co);
    logic [16:0] e;
    int unsigned f;
    if (!rst) begin
      chk($sformatf("d%0d_rst_valid", id), {31'd0, vout}, 32'd0);
      chk($sformatf("d%0d_rst_sum", id), {16'd0, sum}, 32'd0);
      chk($sformatf("d%0d_rst_co", id), {31'd0, co}, 32'd0);
      eq[id].delete();
      aq[id].delete();
      return;
    end
    if (clr) begin
      chk($sformatf("d%0d_clr_ready", id), {31'd0, rdyo}, 32'd0);
      eq[id].delete();
      aq[id].delete();
      return;
    end
    chk($sformatf("d%0d_ready_o", id), {31'd0, rdyo},
        {31'd0, (eq[id].size() < ns) || rdyi});
    chk($sformatf("d%0d_valid_o", id), {31'd0, vout},
        {31'd0, (eq[id].size() > 0) && ((cyc - aq[id][0]) >= ns - 1)});
    if (vout && rdyi && eq[id].size() > 0) begin
      e = eq[id].pop_front();
      void'(aq[id].pop_front());
      chk($sformatf("d%0d_sum_o", id), {16'd0, sum}, {16'd0, e[15:0]});
      chk($sformatf("d%0d_co_o", id), {31'd0, co}, {31'd0, e[16]});
    end
    if (vin && rdyo) begin
      f = 32'(s) + 32'(c);
      e[15:0] = 16'(f & ((32'd1 << w) - 32'd1));
      e[16]   = ((f >> w) & 32'd1) != 0;
      eq[id].push_back(e);
      aq[id].push_back(cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 8, 2, rst_n, clr0, v0, rdyo0, {8'd0, s0}, {8'd0, c0}, vo0, r0, {8'd0, sum0}, co0);
    mon(1, 13, 4, rst_n, 1'b0, vin_r[0], rdyo_r[0], {3'd0, s_r[0]}, {3'd0, c_r[0]},
        vout_r[0], rdy_r[0], {3'd0, sum_r[0]}, co_r[0]);
    mon(2, 13, 1, rst_n, 1'b0, vin_r[1], rdyo_r[1], {3'd0, s_r[1]}, {3'd0, c_r[1]},
        vout_r[1], rdy_r[1], {3'd0, sum_r[1]}, co_r[1]);
  end

  // Random carry-save streams: (S, C) is the 3:2 compression of three operands.
  initial begin
    logic        take [2];
    logic [12:0] a, b, d;
    rand_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vin_r[i] = 1'b0; rdy_r[i] = 1'b0; s_r[i] = '0; c_r[i] = '0;
    end
    @(posedge rst_n);
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) take[i] = vin_r[i] && rdyo_r[i] && rst_n;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        rdy_r[i] = ($urandom % 4) != 0;
        if (!vin_r[i] || take[i]) begin
          a = 13'($urandom); b = 13'($urandom); d = 13'($urandom);
          vin_r[i] = ($urandom % 3) != 0;
          s_r[i]   = a ^ b ^ d;
          c_r[i]   = ((a & b) | (a & d) | (b & d)) << 1;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) take[i] = vin_r[i] && rdyo_r[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!take[i] && vin_r[i]) chk($sformatf("rand%0d_last_offer", i), {31'd0, rdyo_r[i]}, 32'd1);
      vin_r[i] = 1'b0;
      rdy_r[i] = 1'b1;
    end
    repeat (10) step();
    rand_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nv, first, last, n;
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0; v0 = 1'b0; r0 = 1'b0; clr0 = 1'b0; s0 = '0; c0 = '0;
    repeat (3) step();
    chk("reset_valid", {31'd0, vo0}, 32'd0);
    chk("reset_sum", {24'd0, sum0}, 32'd0);
    chk("reset_co", {31'd0, co0}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", {31'd0, rdyo0}, 32'd1);

    // Carry ripples across the chunk boundary
    step(); v0 = 1'b1; s0 = 8'hFF; c0 = 8'h01; r0 = 1'b1;
    step(); v0 = 1'b0;
    step();
    chk("t1_valid", {31'd0, vo0}, 32'd1);
    chk("t1_sum", {24'd0, sum0}, 32'h00);
    chk("t1_co", {31'd0, co0}, 32'd1);

    // 100 back-to-back pairs must come out on 100 consecutive cycles
    nv = 0; first = -1; last = -1;
    for (int i = 0; i < 105; i++) begin
      step();
      if (vo0) begin
        nv++;
        if (first < 0) first = i;
        last = i;
      end
      if (i < 100) begin
        v0 = 1'b1; s0 = 8'($urandom); c0 = 8'($urandom);
      end else begin
        v0 = 1'b0;
      end
    end
    chk("t2_count", nv, 32'd100);
    chk("t2_contiguous", last - first + 1, 32'd100);
    chk("t2_first", first, 32'd2);

    // Backpressure: two fill the pipe, the third waits for ready_i
    step(); r0 = 1'b0; v0 = 1'b1; s0 = 8'h81; c0 = 8'h90; #1;
    chk("t3_ready_a", {31'd0, rdyo0}, 32'd1);
    step(); s0 = 8'h05; c0 = 8'h06; #1;
    chk("t3_ready_b", {31'd0, rdyo0}, 32'd1);
    step(); s0 = 8'hF0; c0 = 8'h0F; #1;
    chk("t3_ready_full", {31'd0, rdyo0}, 32'd0);
    step();
    chk("t3_ready_held", {31'd0, rdyo0}, 32'd0);
    chk("t3_valid", {31'd0, vo0}, 32'd1);
    chk("t3_sum0", {24'd0, sum0}, 32'h11);
    chk("t3_co0", {31'd0, co0}, 32'd1);
    r0 = 1'b1; #1;
    chk("t3_ready_pass", {31'd0, rdyo0}, 32'd1);
    step(); v0 = 1'b0;
    chk("t3_sum1", {24'd0, sum0}, 32'h0B);
    step();
    chk("t3_sum2", {24'd0, sum0}, 32'hFF);
    chk("t3_valid2", {31'd0, vo0}, 32'd1);
    step();
    chk("t3_drained", {31'd0, vo0}, 32'd0);

    // Clear with two entries in flight and a simultaneous offer
    step(); v0 = 1'b1; s0 = 8'h11; c0 = 8'h22;
    step(); s0 = 8'h33; c0 = 8'h44;
    step(); clr0 = 1'b1; s0 = 8'h55; c0 = 8'h66; #1;
    chk("t4_clr_ready", {31'd0, rdyo0}, 32'd0);
    step(); clr0 = 1'b0; v0 = 1'b0;
    chk("t4_flushed_a", {31'd0, vo0}, 32'd0);
    step();
    chk("t4_flushed_b", {31'd0, vo0}, 32'd0);
    step(); v0 = 1'b1; s0 = 8'h10; c0 = 8'h20;
    step(); v0 = 1'b0;
    step();
    chk("t4_valid", {31'd0, vo0}, 32'd1);
    chk("t4_sum", {24'd0, sum0}, 32'h30);
    chk("t4_co", {31'd0, co0}, 32'd0);

    // Asynchronous reset while a result is on the output
    step(); r0 = 1'b0; v0 = 1'b1; s0 = 8'h7F; c0 = 8'h01;
    step(); v0 = 1'b0;
    n = 0;
    while (!vo0 && n < 10) begin
      step();
      n++;
    end
    chk("t5_valid_before", {31'd0, vo0}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, vo0}, 32'd0);
    chk("t5_rst_sum", {24'd0, sum0}, 32'h00);
    step(); step();
    rst_n = 1'b1; r0 = 1'b1;
    step(); v0 = 1'b1; s0 = 8'hC8; c0 = 8'h64;
    step(); v0 = 1'b0;
    step();
    chk("t5_valid_after", {31'd0, vo0}, 32'd1);
    chk("t5_sum_after", {24'd0, sum0}, 32'h2C);
    chk("t5_co_after", {31'd0, co0}, 32'd1);

    n = 0;
    while (!rand_done && n < 2000) begin
      step();
      n++;
    end
    chk("rand_done", {31'd0, rand_done}, 32'd1);
    repeat (3) step();
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d_nothing_lost", i), eq[i].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
